// File: rtl/register_file_mp_if.sv
// Register file access bundle: one write port, NUM_RD packed read ports, clear request and ready.
// Master drives requests and addresses; slave returns combinational read data and ready.
interface register_file_mp_if #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2
);
    logic                     clear_req;
    logic                     wr_en;
    logic [AW-1:0]            wr_reg;
    logic [XLEN-1:0]          wr_data;
    logic [NUM_RD*AW-1:0]     rd_reg;
    logic [NUM_RD*XLEN-1:0]   rd_data;
    logic                     ready;

    modport master (
        output clear_req, wr_en, wr_reg, wr_data, rd_reg,
        input  rd_data, ready
    );

    modport slave (
        input  clear_req, wr_en, wr_reg, wr_data, rd_reg,
        output rd_data, ready
    );
endinterface

// File: rtl/register_file_mp.sv
// Multi-read-port integer register file with x0 hardwired to zero and a sequential clear engine.
// Reads: zero latency, combinational. Writes: commit at posedge. Clear: DEPTH-1 cycles, ready low.
// No backpressure; writes are dropped while not ready. Option macro: REG_FILE_BYPASS_EN (write-through forwarding).
module register_file_mp #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    register_file_mp_if.slave  bus
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE      = AW'(1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_clr_idx;
    logic            r_ready;

    // Storage deliberately has no reset so it can map onto distributed RAM.
    logic [XLEN-1:0] r_mem [DEPTH];

    logic            w_wr_ok;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic [XLEN-1:0] w_mem_din;
    logic [XLEN-1:0] w_port_dat [NUM_RD];
    logic [NUM_RD*XLEN-1:0] w_rd_flat;

    function automatic logic addr_live(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && (a != '0);
    endfunction

    // Clear request wins over a same-cycle write.
    assign w_wr_ok = r_ready & ~bus.clear_req & bus.wr_en & addr_live(bus.wr_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= ONE;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_idx == LAST_IDX) begin
                        r_state <= ST_READY;
                        r_ready <= 1'b1;
                    end else begin
                        r_clr_idx <= r_clr_idx + ONE;
                    end
                end
                ST_READY: begin
                    if (bus.clear_req) begin
                        r_state   <= ST_CLEAR;
                        r_clr_idx <= ONE;
                        r_ready   <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_CLEAR;
                    r_clr_idx <= ONE;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = bus.wr_reg;
        w_mem_din  = bus.wr_data;
        if (r_state == ST_CLEAR) begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_clr_idx;
            w_mem_din  = '0;
        end else if (w_wr_ok) begin
            w_mem_we   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_din;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic            w_valid;
        logic [XLEN-1:0] w_mem_dat;

        assign w_addr    = bus.rd_reg[g*AW +: AW];
        assign w_valid   = r_ready & addr_live(w_addr);
        assign w_mem_dat = w_valid ? r_mem[w_addr] : '0;
`ifdef REG_FILE_BYPASS_EN
        logic w_fwd;
        assign w_fwd          = w_wr_ok & (bus.wr_reg == w_addr);
        assign w_port_dat[g]  = w_fwd ? bus.wr_data : w_mem_dat;
`else
        assign w_port_dat[g]  = w_mem_dat;
`endif
    end

    always_comb begin
        w_rd_flat = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_rd_flat[i*XLEN +: XLEN] = w_port_dat[i];
        end
    end

    assign bus.rd_data = w_rd_flat;
    assign bus.ready   = r_ready;
endmodule

// File: tb/tb_register_file_mp.sv
// Directed + random bench for register_file_mp, checked every cycle against an abstract model.
module tb_register_file_mp;
    localparam int XLEN   = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = $clog2(DEPTH);
`ifdef REG_FILE_BYPASS_EN
    localparam logic [XLEN-1:0] T4_EXP = 32'h1234_5678;
`else
    localparam logic [XLEN-1:0] T4_EXP = 32'h0000_0000;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    register_file_mp_if #(.XLEN(XLEN), .AW(AW), .NUM_RD(NUM_RD)) bus ();

    register_file_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    // Model: logical contents plus edges remaining until the array is usable.
    logic [XLEN-1:0] m_mem [DEPTH];
    int              busy = 0;

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (rst_n !== 1'b1) begin
            busy = DEPTH - 1;
            foreach (m_mem[k]) m_mem[k] = '0;
        end else if (busy > 0) begin
            busy = busy - 1;
        end else if (bus.clear_req) begin
            busy = DEPTH - 1;
            foreach (m_mem[k]) m_mem[k] = '0;
        end else if (bus.wr_en && bus.wr_reg != 0) begin
            m_mem[bus.wr_reg] = bus.wr_data;
        end
    end

    function automatic logic exp_ready();
        return (rst_n === 1'b1) && (busy == 0);
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        if (!exp_ready() || a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (bus.wr_en && !bus.clear_req && bus.wr_reg == a) return bus.wr_data;
`endif
        return m_mem[a];
    endfunction

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("ready", XLEN'(bus.ready), XLEN'(exp_ready()));
            for (int i = 0; i < NUM_RD; i++) begin
                chk($sformatf("rd%0d", i), bus.rd_data[i*XLEN +: XLEN], exp_rd(bus.rd_reg[i*AW +: AW]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic set_rd(input int a, input int b);
        bus.rd_reg = {AW'(b), AW'(a)};
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            cyc();
            n++;
        end
    endtask

    function automatic logic [XLEN-1:0] rd0();
        return bus.rd_data[0 +: XLEN];
    endfunction

    function automatic logic [XLEN-1:0] rd1();
        return bus.rd_data[XLEN +: XLEN];
    endfunction

    initial begin
        int n;
        int a;
        rst_n         = 1'b0;
        bus.clear_req = 1'b0;
        bus.wr_en     = 1'b1;
        bus.wr_reg    = AW'(5);
        bus.wr_data   = 32'hDEAD_BEEF;
        set_rd(5, 5);
        repeat (3) cyc();
        cmp_on = 1'b1;

        // 1: reset, writes held during clear are ignored
        mid();
        chk("t1_rst_ready", XLEN'(bus.ready), 32'd0);
        chk("t1_rst_rd0", rd0(), 32'd0);
        cyc();
        rst_n = 1'b1;
        wait_ready(n);
        chk("t1_ready_edges", XLEN'(n), 32'd31);
        bus.wr_en = 1'b0;
        mid();
        chk("t1_x5_zero", rd0(), 32'd0);

        // 2: write then read on both ports
        cyc();
        bus.wr_en = 1'b1; bus.wr_reg = AW'(5); bus.wr_data = 32'hA5A5_A5A5;
        cyc();
        bus.wr_en = 1'b0;
        mid();
        chk("t2_rd0", rd0(), 32'hA5A5_A5A5);
        chk("t2_rd1", rd1(), 32'hA5A5_A5A5);

        // 3: x0 stays zero
        cyc();
        bus.wr_en = 1'b1; bus.wr_reg = AW'(0); bus.wr_data = 32'hFFFF_FFFF;
        set_rd(0, 0);
        cyc();
        bus.wr_en = 1'b0;
        mid();
        chk("t3_rd0", rd0(), 32'd0);
        chk("t3_rd1", rd1(), 32'd0);

        // 4: same-cycle write and read
        cyc();
        bus.wr_en = 1'b1; bus.wr_reg = AW'(7); bus.wr_data = 32'h1234_5678;
        set_rd(7, 5);
        mid();
        chk("t4_same_cycle", rd0(), T4_EXP);
        chk("t4_other_port", rd1(), 32'hA5A5_A5A5);
        cyc();
        bus.wr_en = 1'b0;
        mid();
        chk("t4_after", rd0(), 32'h1234_5678);

        // 5: fill, then clear with a colliding write
        for (int r = 1; r < DEPTH; r++) begin
            cyc();
            bus.wr_en = 1'b1; bus.wr_reg = AW'(r); bus.wr_data = 32'h1000_0000 + 32'(r) * 32'h101;
        end
        cyc();
        bus.wr_en = 1'b0;
        set_rd(31, 3);
        mid();
        chk("t5_x31", rd0(), 32'h1000_1F1F);
        chk("t5_x3", rd1(), 32'h1000_0303);
        cyc();
        bus.clear_req = 1'b1;
        bus.wr_en = 1'b1; bus.wr_reg = AW'(3); bus.wr_data = 32'h1;
        cyc();
        bus.clear_req = 1'b0;
        bus.wr_en = 1'b0;
        wait_ready(n);
        chk("t5_ready_edges", XLEN'(n), 32'd31);
        for (int r = 0; r < DEPTH; r++) begin
            set_rd(r, 3);
            #1;
            chk($sformatf("t5_cleared_x%0d", r), rd0(), 32'd0);
        end
        chk("t5_x3_after", rd1(), 32'd0);

        // 6: async reset mid-operation and mid-clear
        cyc();
        bus.wr_en = 1'b1; bus.wr_reg = AW'(9); bus.wr_data = 32'h5555_AAAA;
        cyc();
        bus.wr_en = 1'b0;
        set_rd(9, 9);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_op_ready", XLEN'(bus.ready), 32'd0);
        chk("t6_op_rd0", rd0(), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        repeat (9) cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_clr_ready", XLEN'(bus.ready), 32'd0);
        cyc();
        rst_n = 1'b1;
        wait_ready(n);
        chk("t6_ready_edges", XLEN'(n), 32'd31);
        mid();
        chk("t6_x9_zero", rd0(), 32'd0);

        // Random traffic, checked by the per-cycle compare
        for (int k = 0; k < 400; k++) begin
            cyc();
            bus.clear_req = ($urandom_range(63) == 0);
            bus.wr_en     = 1'($urandom_range(1));
            bus.wr_reg    = AW'($urandom_range(DEPTH - 1));
            bus.wr_data   = $urandom;
            a = $urandom_range(DEPTH - 1);
            if ($urandom_range(3) == 0) a = int'(bus.wr_reg);
            set_rd(a, $urandom_range(DEPTH - 1));
        end
        cyc();
        bus.clear_req = 1'b0;
        bus.wr_en     = 1'b0;
        mid();
        cmp_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
